// File: rtl/req_arbiter8_if.sv
// Handshake bundle between the requesters and the eight-way arbiter.
// The master side drives en/req/done; the slave side returns the grant outputs.
`timescale 1ns/1ps
interface req_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [6:0] seg;
    logic       timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_valid, gnt_idx, seg, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_valid, gnt_idx, seg, timeout
    );
endinterface

// File: rtl/req_arbiter8.sv
// Eight-requester single-owner arbiter with hold timeout and 7-seg winner code.
// Define ARB_FIXED_PRIO_EN for highest-index-wins instead of round-robin.
`timescale 1ns/1ps
module req_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    req_arbiter8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       win;
    logic             any_req;
    logic             owner_req;
    logic             hold_hit;
    logic             grant_end;
`ifndef ARB_FIXED_PRIO_EN
    logic [2:0]       last_q, last_d;
`endif

    function automatic logic [6:0] seg_code(input logic [2:0] i);
        logic [6:0] s;
        unique case (i)
            3'd0:    s = 7'h40;
            3'd1:    s = 7'h79;
            3'd2:    s = 7'h24;
            3'd3:    s = 7'h30;
            3'd4:    s = 7'h19;
            3'd5:    s = 7'h12;
            3'd6:    s = 7'h02;
            default: s = 7'h78;
        endcase
        return s;
    endfunction

    assign any_req   = |bus.req;
    assign owner_req = bus.req[idx_q];
    assign hold_hit  = (cnt_q == HOLD_LAST);
    assign grant_end = bus.done | ~owner_req | hold_hit | ~bus.en;

`ifdef ARB_FIXED_PRIO_EN
    // Winner search: highest-index active request wins.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req[i]) win = 3'(i);
        end
    end
`else
    // Winner search: first active request after the last owner, wrapping.
    always_comb begin
        logic [15:0] dbl;
        logic [3:0]  start;
        logic [7:0]  rot;
        logic [2:0]  off;
        logic        found;
        start = {1'b0, last_q} + 4'd1;
        dbl   = {bus.req, bus.req} >> start;
        rot   = dbl[7:0];
        off   = 3'd0;
        found = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (!found && rot[j]) begin
                off   = 3'(j);
                found = 1'b1;
            end
        end
        win = last_q + 3'd1 + off;
    end
`endif

    // Next-state and registered-output computation for IDLE/BUSY/GAP.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.en && any_req) begin
                    gnt_d   = 8'b1 << win;
                    valid_d = 1'b1;
                    idx_d   = win;
                    seg_d   = seg_code(win);
                    cnt_d   = '0;
                    state_d = BUSY;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (grant_end) begin
                    gnt_d   = 8'h00;
                    valid_d = 1'b0;
                    idx_d   = 3'd0;
                    seg_d   = SEG_BLANK;
                    cnt_d   = '0;
                    to_d    = hold_hit & ~bus.done & owner_req & bus.en;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            idx_q   <= 3'd0;
            seg_q   <= SEG_BLANK;
            to_q    <= 1'b0;
            cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 3'd7;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.seg       = seg_q;
    assign bus.timeout   = to_q;
endmodule
